// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for jk_mod_counter: the master drives the controls,
// and the counter (slave) returns its state and flags.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic             tc;
  logic             ovf;

  modport master (
    output en, mode, j, k, load, din,
    input  Q, Qbar, tc, ovf
  );

  modport slave (
    input  en, mode, j, k, load, din,
    output Q, Qbar, tc, ovf
  );
endinterface

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS counter with up/down counting, parallel load and per-bit J/K control.
// Define JK_CNT_SATURATE_EN to make up/down counting stop at the ends instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  jk_mod_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_JK   = 2'b11
  } mode_e;

  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("jk_mod_counter: WIDTH must be in 1..16");
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic [WIDTH-1:0] jk_cand;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  // Per-bit JK characteristic equation: Q+ = J & ~Q | ~K & Q.
  assign jk_cand = (bus.j & ~q_reg) | (~bus.k & q_reg);

  always_comb begin
    q_next   = q_reg;
    ovf_next = ovf_reg;
    if (bus.load) begin
      if ({1'b0, bus.din} < MOD_EXT) begin
        q_next   = bus.din;
        ovf_next = 1'b0;
      end else begin
        q_next   = LAST;
        ovf_next = 1'b1;
      end
    end else if (bus.en) begin
      case (mode)
        MODE_UP: begin
          if (q_reg != LAST) begin
            q_next = q_reg + 1'b1;
          end else begin
`ifdef JK_CNT_SATURATE_EN
            q_next = LAST;
`else
            q_next = '0;
`endif
          end
        end
        MODE_DOWN: begin
          if (q_reg != '0) begin
            q_next = q_reg - 1'b1;
          end else begin
`ifdef JK_CNT_SATURATE_EN
            q_next = '0;
`else
            q_next = LAST;
`endif
          end
        end
        MODE_JK: begin
          if ({1'b0, jk_cand} < MOD_EXT) begin
            q_next = jk_cand;
          end else begin
            q_next   = '0;
            ovf_next = 1'b1;
          end
        end
        default: begin
          q_next = q_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      ovf_reg <= ovf_next;
    end
  end

  // tc flags the edge on which a wrap (or, when saturating, a blocked step) happens.
  assign bus.tc = bus.en && !bus.load &&
                  (((mode == MODE_UP) && (q_reg == LAST)) ||
                   ((mode == MODE_DOWN) && (q_reg == '0)));

  assign bus.Q    = q_reg;
  assign bus.Qbar = ~q_reg;
  assign bus.ovf  = ovf_reg;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10): directed scenarios
// followed by random controls, all checked against an integer reference model.
module tb_jk_mod_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   mq;
  bit   movf;

  jk_mod_counter_if #(.WIDTH(WIDTH)) bus ();

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".Q"}, 32'(bus.Q), 32'(mq));
    checkOutput({tag, ".Qbar"}, 32'(bus.Qbar), 32'((~mq) & ((1 << WIDTH) - 1)));
    checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(movf));
  endtask

  // Reference behaviour in plain integer arithmetic, one clock edge at a time.
  task automatic modelEdge(input bit en, input int mode, input int j, input int k,
                           input bit ld, input int din);
    int cand;
    if (ld) begin
      if (din < MOD) begin
        mq   = din;
        movf = 0;
      end else begin
        mq   = MOD - 1;
        movf = 1;
      end
    end else if (en) begin
      case (mode)
        1: begin
`ifdef JK_CNT_SATURATE_EN
          if (mq < MOD - 1) mq = mq + 1;
`else
          mq = (mq + 1) % MOD;
`endif
        end
        2: begin
`ifdef JK_CNT_SATURATE_EN
          if (mq > 0) mq = mq - 1;
`else
          mq = (mq + MOD - 1) % MOD;
`endif
        end
        3: begin
          cand = ((mq | (j & ~k)) & ~(k & ~j)) ^ (j & k);
          cand = cand & ((1 << WIDTH) - 1);
          if (cand < MOD) mq = cand;
          else begin
            mq   = 0;
            movf = 1;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic applyStimulus(input string tag, input bit en, input int mode, input int j,
                               input int k, input bit ld, input int din);
    bit exp_tc;
    @(negedge clk);
    bus.en   = en;
    bus.mode = 2'(mode);
    bus.j    = WIDTH'(j);
    bus.k    = WIDTH'(k);
    bus.load = ld;
    bus.din  = WIDTH'(din);
    #1;
    exp_tc = en && !ld && ((mode == 1 && mq == MOD - 1) || (mode == 2 && mq == 0));
    checkOutput({tag, ".tc"}, 32'(bus.tc), 32'(exp_tc));
    @(posedge clk);
    modelEdge(en, mode, j, k, ld, din);
    #1;
    checkState(tag);
  endtask

  // Pulses rst between edges with the controls idle so the release edge does nothing.
  task automatic applyReset(input string tag);
    @(negedge clk);
    #2;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    rst      = 1'b0;
    mq       = 0;
    movf     = 0;
    #1;
    checkState(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    mq       = 0;
    movf     = 0;
    rst      = 1'b0;
    bus.en   = 1'b0;
    bus.mode = 2'b00;
    bus.j    = '0;
    bus.k    = '0;
    bus.load = 1'b0;
    bus.din  = '0;
    #12;
    checkState("por");
    rst = 1'b1;

    for (int i = 0; i < 7; i++) applyStimulus("pre_up", 1, 1, 0, 0, 0, 0);
    checkOutput("at_seven", 32'(bus.Q), 32'd7);
    applyReset("mid_reset");

    for (int i = 0; i < 12; i++) applyStimulus("up", 1, 1, 0, 0, 0, 0);

    applyStimulus("load2", 0, 0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) applyStimulus("down", 1, 2, 0, 0, 0, 0);

    applyStimulus("load12", 0, 0, 0, 0, 1, 12);
    checkOutput("load12_ovf", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus("ovf_keep", 1, 1, 0, 0, 0, 0);
    applyStimulus("load3", 0, 0, 0, 0, 1, 3);
    applyStimulus("load_vs_up", 1, 1, 0, 0, 1, 6);
    checkOutput("load_wins", 32'(bus.Q), 32'd6);

    applyStimulus("load5", 0, 0, 0, 0, 1, 5);
    applyStimulus("jk_ovf", 1, 3, 4'b1000, 4'b0001, 0, 0);
    applyStimulus("jk_tog", 1, 3, 4'b0011, 4'b0011, 0, 0);
    checkOutput("jk_tog_val", 32'(bus.Q), 32'd3);

    for (int i = 0; i < 3; i++) applyStimulus("hold_en0", 0, 1, 0, 0, 0, 0);
    applyStimulus("hold_m00", 1, 0, 0, 0, 0, 0);

    applyStimulus("load_hi_jk", 1, 3, 4'b1111, 4'b0000, 1, 15);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        applyReset("rnd_reset");
      end else begin
        applyStimulus("rnd", bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      bit'($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
